// File: rtl/kmp_ff_gen.sv
// KMP failure-function generator: builds lps[] for one captured pattern,
// one algorithm step per clock, and holds the table for the downstream PEs.
module kmp_ff_gen #(
   parameter int MAX_PATTERN = 8,
   parameter int BYTE        = 8,
   parameter int MAX_PAT_ADD = 3
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [MAX_PATTERN*BYTE-1:0]        pat_input,
   input  logic [MAX_PAT_ADD-1:0]             pat_last_idx,
   input  logic                               input_valid,
   output logic                               output_valid,
   output logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_result
);

   localparam int PW = MAX_PATTERN * BYTE;
   localparam int FW = MAX_PAT_ADD * MAX_PATTERN;
   localparam logic [MAX_PAT_ADD:0]   I_ONE   = (MAX_PAT_ADD + 1)'(1);
   localparam logic [MAX_PAT_ADD-1:0] LEN_ONE = MAX_PAT_ADD'(1);

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_INIT = 4'b0010,
      S_COMP = 4'b0100,
      S_DONE = 4'b1000
   } state_t;

   state_t                   state_q, state_d;
   logic [PW-1:0]            pat_q, pat_d;
   logic [MAX_PAT_ADD-1:0]   last_q, last_d;
   logic [FW-1:0]            ff_q, ff_d;
   logic [MAX_PAT_ADD:0]     i_q, i_d;
   logic [MAX_PAT_ADD-1:0]   len_q, len_d;
   logic                     output_valid_q, output_valid_d;
   logic [MAX_PAT_ADD-1:0]   last_in_s;
   logic [MAX_PAT_ADD-1:0]   i_idx_s;
   logic                     finished_s;

   function automatic logic [BYTE-1:0] pat_char(input logic [PW-1:0] p,
                                                input logic [MAX_PAT_ADD-1:0] k);
      pat_char = p[k*BYTE +: BYTE];
   endfunction

   function automatic logic [MAX_PAT_ADD-1:0] ff_slot(input logic [FW-1:0] t,
                                                      input logic [MAX_PAT_ADD-1:0] k);
      ff_slot = t[k*MAX_PAT_ADD +: MAX_PAT_ADD];
   endfunction

   // Index range only needs clamping when the index field can exceed the slot count.
   generate
      if (MAX_PATTERN < (2 ** MAX_PAT_ADD)) begin : g_clamp
         always_comb begin
            if (pat_last_idx >= MAX_PAT_ADD'(MAX_PATTERN - 1)) begin
               last_in_s = MAX_PAT_ADD'(MAX_PATTERN - 1);
            end else begin
               last_in_s = pat_last_idx;
            end
         end
      end else begin : g_no_clamp
         assign last_in_s = pat_last_idx;
      end
   endgenerate

   assign finished_s = (i_q > {1'b0, last_q});
   assign i_idx_s    = i_q[MAX_PAT_ADD-1:0];

   // Next-state, table step and output-valid decode.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      last_d  = last_q;
      ff_d    = ff_q;
      i_d     = i_q;
      len_d   = len_q;
      case (state_q)
         S_IDLE: begin
            if (input_valid) begin
               state_d = S_INIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_INIT: begin
            pat_d   = pat_input;
            last_d  = last_in_s;
            ff_d    = '0;
            i_d     = I_ONE;
            len_d   = '0;
            state_d = S_COMP;
         end
         S_COMP: begin
            if (finished_s) begin
               if (input_valid) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (pat_char(pat_q, i_idx_s) == pat_char(pat_q, len_q)) begin
               ff_d[i_idx_s*MAX_PAT_ADD +: MAX_PAT_ADD] = len_q + LEN_ONE;
               len_d = len_q + LEN_ONE;
               i_d   = i_q + I_ONE;
            end else if (len_q != '0) begin
               // Fall back along the partially built table; i holds its position.
               len_d = ff_slot(ff_q, len_q - LEN_ONE);
            end else begin
               ff_d[i_idx_s*MAX_PAT_ADD +: MAX_PAT_ADD] = '0;
               i_d = i_q + I_ONE;
            end
         end
         S_DONE: begin
            if (!input_valid) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            i_d     = I_ONE;
            len_d   = '0;
         end
      endcase
      output_valid_d = (state_d == S_DONE);
   end

   // State, captured job and table registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         pat_q          <= '0;
         last_q         <= '0;
         ff_q           <= '0;
         i_q            <= I_ONE;
         len_q          <= '0;
         output_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pat_q          <= pat_d;
         last_q         <= last_d;
         ff_q           <= ff_d;
         i_q            <= i_d;
         len_q          <= len_d;
         output_valid_q <= output_valid_d;
      end
   end

   assign output_valid = output_valid_q;
   assign ff_result    = ff_q;

endmodule

// File: tb/tb_kmp_ff_gen.sv
// Scoreboard bench for kmp_ff_gen: brute-force prefix/suffix model, directed
// and random jobs, handshake, mid-job input changes and reset abort.
module tb_kmp_ff_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] pat_input;
   logic [2:0]  pat_last_idx;
   logic        input_valid;
   logic        output_valid;
   logic [23:0] ff_result;

   kmp_ff_gen #(.MAX_PATTERN(8), .BYTE(8), .MAX_PAT_ADD(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .pat_input    (pat_input),
      .pat_last_idx (pat_last_idx),
      .input_valid  (input_valid),
      .output_valid (output_valid),
      .ff_result    (ff_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int          id;
      logic [23:0] ff;
      int          rise_cyc;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   logic prev_ov = 1'b0;
   int   job_id = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ch(input logic [63:0] p, input int k);
      return p[k*8 +: 8];
   endfunction

   // lps[j] = longest L<=j with pat[0..L-1] == pat[j-L+1..j], found by brute force
   function automatic logic [23:0] ref_lps(input logic [63:0] p, input int last);
      logic [23:0] r;
      r = '0;
      for (int j = 1; j <= last; j++) begin
         int best;
         best = 0;
         for (int l = 1; l <= j; l++) begin
            bit ok;
            ok = 1'b1;
            for (int t = 0; t < l; t++)
               if (ch(p, t) != ch(p, j - l + 1 + t)) ok = 1'b0;
            if (ok) best = l;
         end
         r[j*3 +: 3] = 3'(best);
      end
      return r;
   endfunction

   // Number of algorithm steps the defined KMP procedure takes on this pattern
   function automatic int ref_steps(input logic [63:0] p, input int last);
      logic [23:0] lp;
      int i, len, s;
      lp = ref_lps(p, last);
      i = 1; len = 0; s = 0;
      while (i <= last) begin
         s++;
         if (ch(p, i) == ch(p, len)) begin
            len++; i++;
         end else if (len != 0) begin
            len = int'(lp[(len-1)*3 +: 3]);
         end else begin
            i++;
         end
      end
      return s;
   endfunction

   function automatic logic [63:0] mk(input string s);
      logic [63:0] p;
      p = {$urandom, $urandom};
      for (int k = 0; k < s.len(); k++) p[k*8 +: 8] = s[k];
      return p;
   endfunction

   // Monitor: every rising output_valid must match the oldest expected job
   always @(negedge clk) begin
      if (output_valid && !prev_ov) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got output_valid=1 expected 0 (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            check($sformatf("job%0d_ff", mon_e.id), 32'(ff_result), 32'(mon_e.ff));
            check($sformatf("job%0d_latency", mon_e.id), cyc, mon_e.rise_cyc);
         end
      end
      prev_ov <= output_valid;
   end

   task automatic start(input logic [63:0] p, input int last);
      pat_input    = p;
      pat_last_idx = 3'(last);
      input_valid  = 1'b1;
   endtask

   task automatic wait_ov(input int id, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         if (output_valid) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL job%0d_timeout: got no output_valid expected within 40 cycles", id);
      end
   endtask

   // Called at a negedge; mut >= 0 scrambles the inputs that many cycles into the job
   task automatic run_job(input logic [63:0] p, input int last, input int extra, input int mut);
      exp_t e;
      bit   ok;
      job_id++;
      e.id       = job_id;
      e.ff       = ref_lps(p, last);
      e.rise_cyc = cyc + ref_steps(p, last) + 3;
      sb.push_back(e);
      start(p, last);
      if (mut >= 0) begin
         repeat (mut) @(negedge clk);
         pat_input    = {$urandom, $urandom};
         pat_last_idx = 3'($urandom_range(0, 7));
      end
      wait_ov(job_id, ok);
      if (ok) begin
         for (int k = 0; k < extra; k++) begin
            @(negedge clk);
            check($sformatf("job%0d_hold%0d", job_id, k), 32'(output_valid), 32'd1);
         end
         input_valid = 1'b0;
         @(negedge clk);
         check($sformatf("job%0d_fall", job_id), 32'(output_valid), 32'd0);
      end else begin
         input_valid = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   initial begin
      logic [63:0] p;
      int          last;
      reset        = 1'b1;
      input_valid  = 1'b0;
      pat_input    = 64'h0;
      pat_last_idx = 3'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_valid", 32'(output_valid), 32'd0);
      check("reset_ff", 32'(ff_result), 32'd0);

      run_job(mk("a"), 0, 0, -1);
      run_job(mk("abab"), 3, 0, -1);
      run_job(mk("aabaaab"), 6, 0, -1);
      run_job(mk("aaaa"), 3, 3, -1);
      run_job(mk("abcd"), 3, 0, -1);

      // Inputs scrambled while COMP is running
      run_job(mk("abaab"), 4, 1, 2);
      run_job(mk("aaabaa"), 5, 0, 3);

      // input_valid dropped mid-job: table completes, valid never rises
      p = mk("abacaba");
      start(p, 6);
      repeat (2) @(negedge clk);
      input_valid = 1'b0;
      repeat (20) @(negedge clk);
      check("drop_ff_retained", 32'(ff_result), 32'(ref_lps(p, 6)));
      check("drop_valid", 32'(output_valid), 32'd0);

      // Reset at E3 aborts the job
      start(mk("aabaaab"), 6);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_valid", 32'(output_valid), 32'd0);
      check("abort_ff", 32'(ff_result), 32'd0);
      reset       = 1'b0;
      input_valid = 1'b0;
      @(negedge clk);
      run_job(mk("aabaaab"), 6, 0, -1);

      for (int n = 0; n < 20; n++) begin
         last = $urandom_range(0, 7);
         p    = {$urandom, $urandom};
         for (int k = 0; k <= last; k++) p[k*8 +: 8] = 8'h61 + 8'($urandom_range(0, 2));
         run_job(p, last, $urandom_range(0, 2), -1);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
